dat_controller_mb: RTL and testbench

Parametrised multi-block successor of the single-block DAT line controller. It accepts a read or write request from the host with a block count, sequences the physical layer through command, FIFO check, transmit and acknowledge phases for every block, and reports progress and completion to the host. It adds abort and error reporting, and an optional per-phase watchdog. It sits between the host register interface and the DAT physical layer, next to the FIFO controller.

---
 rtl/dat_pkg.sv | 50 +++++
 rtl/dat_watchdog.sv | 32 +++
 rtl/dat_controller_mb.sv | 149 ++++++++++++++
 tb/tb_dat_controller_mb.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dat_pkg.sv
// Shared types for the multi-block DAT line controller: state encoding, default widths
// and the per-state output decode.
package dat_pkg;

  localparam int unsigned DAT_BLK_CNT_W   = 8;
  localparam int unsigned DAT_TIMEOUT_W   = 16;
  localparam int unsigned DAT_TIMEOUT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CMD        = 3'd1,
    CHECK_FIFO = 3'd2,
    TRANSMIT   = 3'd3,
    ACK        = 3'd4
  } dat_state_e;

  typedef struct packed {
    logic busy;
    logic strobe;
    logic ack;
    logic wr;
    logic rd;
  } dat_out_t;

  // Direction flags span CMD through the last ACK; unused encodings decode to all-zero.
  function automatic dat_out_t dat_decode(input dat_state_e state, input logic dir_write);
    dat_out_t out;
    out = '0;
    case (state)
      CMD: begin
        out.busy   = 1'b1;
        out.strobe = 1'b1;
      end
      CHECK_FIFO: out.busy = 1'b1;
      TRANSMIT: begin
        out.busy   = 1'b1;
        out.strobe = 1'b1;
      end
      ACK: begin
        out.busy = 1'b1;
        out.ack  = 1'b1;
      end
      default: out = '0;
    endcase
    out.wr = out.busy & dir_write;
    out.rd = out.busy & ~dir_write;
    return out;
  endfunction

endpackage

// File: rtl/dat_watchdog.sv
// Per-phase watchdog: counts cycles while enabled, restarts on clear, flags expiry one
// cycle before the count would reach TIMEOUT_MAX so the phase lasts exactly TIMEOUT_MAX cycles.
module dat_watchdog
  import dat_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = DAT_TIMEOUT_W,
  parameter int unsigned TIMEOUT_MAX = DAT_TIMEOUT_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] LastCount = TIMEOUT_W'(TIMEOUT_MAX - 1);

  logic [TIMEOUT_W-1:0] r_count;

  assign o_expire = i_enable && (r_count == LastCount);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/dat_controller_mb.sv
// Multi-block DAT line controller: CMD once, then CHECK_FIFO/TRANSMIT/ACK per block.
// Optional per-phase watchdog enabled by defining DAT_CTRL_TIMEOUT_EN.
module dat_controller_mb
  import dat_pkg::*;
#(
  parameter int unsigned BLK_CNT_W   = DAT_BLK_CNT_W,
  parameter int unsigned TIMEOUT_W   = DAT_TIMEOUT_W,
  parameter int unsigned TIMEOUT_MAX = DAT_TIMEOUT_MAX
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 writeRead,
  input  logic                 newDat,
  input  logic [BLK_CNT_W-1:0] block_count,
  input  logic                 abort,
  input  logic                 serial_ready,
  input  logic                 complete,
  input  logic                 ack_in,
  input  logic                 fifo_okay,
  output logic                 busy,
  output logic                 write_Data,
  output logic                 read_Data,
  output logic                 transfer_complete,
  output logic [BLK_CNT_W-1:0] blocks_done,
  output logic                 error,
  output logic                 strobe_out,
  output logic                 ack_out
);

  if (BLK_CNT_W == 0 || TIMEOUT_W == 0 || TIMEOUT_MAX == 0) begin : g_bad_cfg
    $error("dat_controller_mb: widths and TIMEOUT_MAX must be non-zero");
  end

  dat_state_e           r_state, w_next_state;
  logic [BLK_CNT_W-1:0] r_count, w_count_nxt;
  logic [BLK_CNT_W-1:0] r_blocks_done, w_blocks_done_nxt, w_blocks_inc;
  logic                 r_dir, w_dir_nxt;
  logic                 w_error, w_last_ack, w_expire;
  dat_out_t             w_out;

  logic r_busy, r_write, r_read, r_tc, r_error, r_strobe, r_ack;

`ifdef DAT_CTRL_TIMEOUT_EN
  logic w_state_change, w_wd_enable;

  assign w_state_change = (w_next_state != r_state);
  assign w_wd_enable    = (r_state != IDLE);

  dat_watchdog #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_state_change),
    .i_enable(w_wd_enable),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  assign w_blocks_inc = r_blocks_done + BLK_CNT_W'(1);

  always_comb begin
    w_next_state      = r_state;
    w_count_nxt       = r_count;
    w_dir_nxt         = r_dir;
    w_blocks_done_nxt = r_blocks_done;
    w_error           = 1'b0;
    w_last_ack        = 1'b0;

    // Abort and watchdog expiry outrank every other input; blocks_done is kept for readback.
    if (r_state != IDLE && (abort || w_expire)) begin
      w_next_state = IDLE;
      w_error      = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (newDat) begin
            if (block_count != '0) begin
              w_next_state      = CMD;
              w_dir_nxt         = writeRead;
              w_count_nxt       = block_count;
              w_blocks_done_nxt = '0;
            end else begin
              w_error = 1'b1;
            end
          end
        end
        CMD:        if (serial_ready) w_next_state = CHECK_FIFO;
        CHECK_FIFO: if (fifo_okay)    w_next_state = TRANSMIT;
        TRANSMIT:   if (complete)     w_next_state = ACK;
        ACK: begin
          if (ack_in) begin
            w_blocks_done_nxt = w_blocks_inc;
            if (w_blocks_inc == r_count) begin
              w_next_state = IDLE;
              w_last_ack   = 1'b1;
            end else begin
              w_next_state = CHECK_FIFO;
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end

    w_out = dat_decode(w_next_state, w_dir_nxt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_dir         <= 1'b0;
      r_blocks_done <= '0;
      r_busy        <= 1'b0;
      r_write       <= 1'b0;
      r_read        <= 1'b0;
      r_tc          <= 1'b0;
      r_error       <= 1'b0;
      r_strobe      <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_count       <= w_count_nxt;
      r_dir         <= w_dir_nxt;
      r_blocks_done <= w_blocks_done_nxt;
      r_busy        <= w_out.busy;
      r_write       <= w_out.wr;
      r_read        <= w_out.rd;
      r_tc          <= w_last_ack;
      r_error       <= w_error;
      r_strobe      <= w_out.strobe;
      r_ack         <= w_out.ack;
    end
  end

  assign busy              = r_busy;
  assign write_Data        = r_write;
  assign read_Data         = r_read;
  assign transfer_complete = r_tc;
  assign blocks_done       = r_blocks_done;
  assign error             = r_error;
  assign strobe_out        = r_strobe;
  assign ack_out           = r_ack;

endmodule

// File: tb/tb_dat_controller_mb.sv
// Directed bench for dat_controller_mb: expected output words queued per step, checked after each edge.
module tb_dat_controller_mb;

  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] WR = 7'b1000000;
  localparam logic [6:0] ND = 7'b0100000;
  localparam logic [6:0] AB = 7'b0010000;
  localparam logic [6:0] SR = 7'b0001000;
  localparam logic [6:0] CP = 7'b0000100;
  localparam logic [6:0] AK = 7'b0000010;
  localparam logic [6:0] FO = 7'b0000001;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       writeRead = 1'b0, newDat = 1'b0, abort = 1'b0, serial_ready = 1'b0;
  logic       complete = 1'b0, ack_in = 1'b0, fifo_okay = 1'b0;
  logic [7:0] block_count = '0;
  logic       busy, write_Data, read_Data, transfer_complete, error, strobe_out, ack_out;
  logic [7:0] blocks_done;

  logic [14:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  dat_controller_mb #(
    .BLK_CNT_W  (8),
    .TIMEOUT_W  (16),
    .TIMEOUT_MAX(10)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .writeRead        (writeRead),
    .newDat           (newDat),
    .block_count      (block_count),
    .abort            (abort),
    .serial_ready     (serial_ready),
    .complete         (complete),
    .ack_in           (ack_in),
    .fifo_okay        (fifo_okay),
    .busy             (busy),
    .write_Data       (write_Data),
    .read_Data        (read_Data),
    .transfer_complete(transfer_complete),
    .blocks_done      (blocks_done),
    .error            (error),
    .strobe_out       (strobe_out),
    .ack_out          (ack_out)
  );

  always #5 clock = ~clock;

  // Expected word: {busy, write, read, transfer_complete, error, strobe, ack, blocks_done}
  function automatic logic [14:0] e(input logic bs, input logic wd, input logic rd,
                                    input logic tc, input logic er, input logic st,
                                    input logic ak, input logic [7:0] bd);
    return {bs, wd, rd, tc, er, st, ak, bd};
  endfunction

  task automatic check(input string tag);
    logic [14:0] obs;
    logic [14:0] want;
    obs  = {busy, write_Data, read_Data, transfer_complete, error, strobe_out, ack_out,
            blocks_done};
    want = sb.pop_front();
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] in, input logic [7:0] bc,
                      input logic [14:0] want);
    {writeRead, newDat, abort, serial_ready, complete, ack_in, fifo_okay} = in;
    block_count = bc;
    sb.push_back(want);
    @(posedge clock);
    #1;
    check(tag);
  endtask

  task automatic run_one(input logic dir);
    step("one_cmd", (dir ? WR : NO) | ND, 8'd1, e(1, dir, !dir, 0, 0, 1, 0, 8'd0));
    step("one_chk", SR, 8'd0, e(1, dir, !dir, 0, 0, 0, 0, 8'd0));
    step("one_tx", FO, 8'd0, e(1, dir, !dir, 0, 0, 1, 0, 8'd0));
    step("one_ack", CP, 8'd0, e(1, dir, !dir, 0, 0, 0, 1, 8'd0));
    step("one_done", AK, 8'd0, e(0, 0, 0, 1, 0, 0, 0, 8'd1));
    step("one_idle", NO, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd1));
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout observed=no_finish expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    sb.push_back(e(0, 0, 0, 0, 0, 0, 0, 8'd0));
    check("reset_state");
    reset = 1'b1;

    // Single-block write
    run_one(1'b1);

    // Three-block read; newDat during ACK must be ignored
    step("rd3_cmd", ND, 8'd3, e(1, 0, 1, 0, 0, 1, 0, 8'd0));
    step("rd3_chk", SR, 8'd3, e(1, 0, 1, 0, 0, 0, 0, 8'd0));
    step("rd3_wait", NO, 8'd3, e(1, 0, 1, 0, 0, 0, 0, 8'd0));
    for (int b = 0; b < 3; b++) begin
      step("rd3_tx", FO, 8'd3, e(1, 0, 1, 0, 0, 1, 0, 8'(b)));
      step("rd3_ack", CP, 8'd3, e(1, 0, 1, 0, 0, 0, 1, 8'(b)));
      if (b < 2) step("rd3_next", AK | ND, 8'd3, e(1, 0, 1, 0, 0, 0, 0, 8'(b + 1)));
      else       step("rd3_done", AK, 8'd3, e(0, 0, 0, 1, 0, 0, 0, 8'd3));
    end
    step("rd3_idle", NO, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd3));

    // Zero block count rejected
    step("zero_err", WR | ND, 8'd0, e(0, 0, 0, 0, 1, 0, 0, 8'd3));
    step("zero_idle", NO, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd3));

    // Abort in TRANSMIT of block 2 of 4, abort beats complete
    step("ab_cmd", WR | ND, 8'd4, e(1, 1, 0, 0, 0, 1, 0, 8'd0));
    step("ab_chk", SR, 8'd0, e(1, 1, 0, 0, 0, 0, 0, 8'd0));
    step("ab_tx1", FO, 8'd0, e(1, 1, 0, 0, 0, 1, 0, 8'd0));
    step("ab_ack1", CP, 8'd0, e(1, 1, 0, 0, 0, 0, 1, 8'd0));
    step("ab_chk2", AK, 8'd0, e(1, 1, 0, 0, 0, 0, 0, 8'd1));
    step("ab_tx2", FO, 8'd0, e(1, 1, 0, 0, 0, 1, 0, 8'd1));
    step("ab_abort", AB | CP, 8'd0, e(0, 0, 0, 0, 1, 0, 0, 8'd1));
    step("ab_idle", NO, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd1));
    step("ab_in_idle", AB, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd1));

    // Asynchronous reset between edges while in ACK
    step("rst_cmd", ND, 8'd2, e(1, 0, 1, 0, 0, 1, 0, 8'd0));
    step("rst_chk", SR, 8'd0, e(1, 0, 1, 0, 0, 0, 0, 8'd0));
    step("rst_tx", FO, 8'd0, e(1, 0, 1, 0, 0, 1, 0, 8'd0));
    step("rst_ack", CP, 8'd0, e(1, 0, 1, 0, 0, 0, 1, 8'd0));
    {writeRead, newDat, abort, serial_ready, complete, ack_in, fifo_okay} = NO;
    #2 reset = 1'b0;
    #1;
    sb.push_back(e(0, 0, 0, 0, 0, 0, 0, 8'd0));
    check("rst_async");
    #1 reset = 1'b1;
    step("rst_idle", NO, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd0));
    run_one(1'b1);

    // Long wait in CHECK_FIFO
    step("wd_cmd", WR | ND, 8'd1, e(1, 1, 0, 0, 0, 1, 0, 8'd0));
    step("wd_chk", SR, 8'd0, e(1, 1, 0, 0, 0, 0, 0, 8'd0));
`ifdef DAT_CTRL_TIMEOUT_EN
    for (int i = 0; i < 9; i++) step("wd_wait", NO, 8'd0, e(1, 1, 0, 0, 0, 0, 0, 8'd0));
    step("wd_expire", NO, 8'd0, e(0, 0, 0, 0, 1, 0, 0, 8'd0));
`else
    for (int i = 0; i < 12; i++) step("wd_wait", NO, 8'd0, e(1, 1, 0, 0, 0, 0, 0, 8'd0));
    step("wd_abort", AB, 8'd0, e(0, 0, 0, 0, 1, 0, 0, 8'd0));
`endif
    step("wd_idle", NO, 8'd0, e(0, 0, 0, 0, 0, 0, 0, 8'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
